// File: rtl/pixel_framebuffer_if.sv
// rtl/pixel_framebuffer_if.sv - drawer write, clear control and read port bundle for pixel_framebuffer
//
// Purpose: groups the drawer pixel-write port, the clear handshake, the
// registered read port and the statistics counters of pixel_framebuffer.
// Ports (signals):
//   VGA_x/VGA_y/VGA_color/VGA_write  drawer pixel write
//   clear, busy, clear_done          clear-to-background control
//   rd_x/rd_y, rd_color              one-cycle-latency read port
//   pix_count, oob_count             saturating statistics
// Modports: master = drawer/scan-out side, slave = framebuffer.
interface pixel_framebuffer_if #(
    parameter int nX          = 8,
    parameter int nY          = 7,
    parameter int COLOR_DEPTH = 3
);
    logic [nX-1:0]          VGA_x;
    logic [nY-1:0]          VGA_y;
    logic [COLOR_DEPTH-1:0] VGA_color;
    logic                   VGA_write;
    logic                   clear;
    logic                   busy;
    logic                   clear_done;
    logic [nX-1:0]          rd_x;
    logic [nY-1:0]          rd_y;
    logic [COLOR_DEPTH-1:0] rd_color;
    logic [15:0]            pix_count;
    logic [15:0]            oob_count;

    modport master (
        output VGA_x, VGA_y, VGA_color, VGA_write, clear, rd_x, rd_y,
        input  busy, clear_done, rd_color, pix_count, oob_count
    );

    modport slave (
        input  VGA_x, VGA_y, VGA_color, VGA_write, clear, rd_x, rd_y,
        output busy, clear_done, rd_color, pix_count, oob_count
    );
endinterface

// File: rtl/pixel_framebuffer.sv
// rtl/pixel_framebuffer.sv - on-chip pixel framebuffer with clear sequencer and registered read port
//
// Purpose: stores drawer pixel writes in a {y,x}-addressed memory, clears the
// visible area to BG_COLOR on request, and returns stored pixels with a
// one-cycle read latency.
// Ports:
//   Clock  rising-edge system clock
//   Reset  synchronous active-high reset (memory contents are kept)
//   fb     pixel_framebuffer_if.slave: drawer write, clear/busy/clear_done,
//          rd_x/rd_y -> rd_color, pix_count, oob_count
// Optional feature macro: PIXEL_FB_BOUNDS_CHECK_EN
//   defined   - writes outside WIDTH x HEIGHT are dropped and counted in oob_count
//   undefined - such writes are stored off-screen, oob_count is tied to 0
module pixel_framebuffer #(
    parameter RESOLUTION = "160x120",
    parameter int nX     = (RESOLUTION == "640x480") ? 10 : (RESOLUTION == "320x240") ? 9 : 8,
    parameter int nY     = (RESOLUTION == "640x480") ? 9  : (RESOLUTION == "320x240") ? 8 : 7,
    parameter int WIDTH  = (RESOLUTION == "640x480") ? 640 : (RESOLUTION == "320x240") ? 320 : 160,
    parameter int HEIGHT = (RESOLUTION == "640x480") ? 480 : (RESOLUTION == "320x240") ? 240 : 120,
    parameter int COLOR_DEPTH = 3,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR = '0
) (
    input logic               Clock,
    input logic               Reset,
    pixel_framebuffer_if.slave fb
);
    localparam int ADDR_W = nX + nY;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [nX-1:0] X_LAST = nX'(WIDTH - 1);
    localparam logic [nY-1:0] Y_LAST = nY'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [nX-1:0]          cx_q, cx_d;
    logic [nY-1:0]          cy_q, cy_d;
    logic [COLOR_DEPTH-1:0] rd_color_q;
    logic [15:0]            pix_count_q;
    logic                   start_clear;

    logic [COLOR_DEPTH-1:0] mem [0:DEPTH-1];

    logic                   clearing;
    logic                   drawer_ok;
    logic                   accept;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [COLOR_DEPTH-1:0] wdata;

    // Clear sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        start_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fb.clear) begin
                    state_d     = S_CLEAR;
                    cx_d        = '0;
                    cy_d        = '0;
                    start_clear = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (fb.clear) begin
                    state_d     = S_CLEAR;
                    cx_d        = '0;
                    cy_d        = '0;
                    start_clear = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign clearing  = (state_q == S_CLEAR);
    assign drawer_ok = fb.VGA_write && !clearing;

`ifdef PIXEL_FB_BOUNDS_CHECK_EN
    localparam logic [nX:0] X_LIM = (nX + 1)'(WIDTH);
    localparam logic [nY:0] Y_LIM = (nY + 1)'(HEIGHT);

    logic        in_range;
    logic        oob_hit;
    logic [15:0] oob_count_q;

    assign in_range = ({1'b0, fb.VGA_x} < X_LIM) && ({1'b0, fb.VGA_y} < Y_LIM);
    assign accept   = drawer_ok && in_range;
    assign oob_hit  = drawer_ok && !in_range;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oob_count_q <= '0;
        end else if (oob_hit && (oob_count_q != 16'hFFFF)) begin
            oob_count_q <= oob_count_q + 16'd1;
        end
    end

    assign fb.oob_count = oob_count_q;
`else
    assign accept       = drawer_ok;
    assign fb.oob_count = '0;
`endif

    // One shared write port: busy keeps the drawer out while the sequencer
    // owns memory. Reset blocks the write so an aborted clear stops at once.
    assign we    = !Reset && (clearing || accept);
    assign waddr = clearing ? {cy_q, cx_q} : {fb.VGA_y, fb.VGA_x};
    assign wdata = clearing ? BG_COLOR : fb.VGA_color;

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_color_q <= '0;
        end else begin
            rd_color_q <= mem[{fb.rd_y, fb.rd_x}];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            pix_count_q <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            if (start_clear) begin
                pix_count_q <= '0;
            end else if (accept && (pix_count_q != 16'hFFFF)) begin
                pix_count_q <= pix_count_q + 16'd1;
            end
        end
    end

    assign fb.busy       = clearing;
    assign fb.clear_done = (state_q == S_DONE);
    assign fb.rd_color   = rd_color_q;
    assign fb.pix_count  = pix_count_q;
endmodule

// File: tb/tb_pixel_framebuffer.sv
// tb/tb_pixel_framebuffer.sv - self-checking bench for pixel_framebuffer
module tb_pixel_framebuffer;
    localparam int W = 160;
    localparam int H = 120;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [2:0] ref_mem [0:255][0:127];
    int         exp_pix;
    int         exp_oob;

    pixel_framebuffer_if #(.nX(8), .nY(7), .COLOR_DEPTH(3)) fb ();

    pixel_framebuffer dut (
        .Clock (clk),
        .Reset (rst),
        .fb    (fb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic write_px(input int x, input int y, input int c);
        fb.VGA_x = 8'(x); fb.VGA_y = 7'(y); fb.VGA_color = 3'(c); fb.VGA_write = 1'b1;
        tick();
        fb.VGA_write = 1'b0;
        ref_mem[x][y] = 3'(c);
        exp_pix++;
    endtask

    task automatic read_px(input int x, input int y);
        fb.rd_x = 8'(x); fb.rd_y = 7'(y);
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", int'(fb.busy), 0);
        chk("reset_clear_done", int'(fb.clear_done), 0);
        chk("reset_rd_color", int'(fb.rd_color), 0);
        chk("reset_pix_count", int'(fb.pix_count), 0);
        chk("reset_oob_count", int'(fb.oob_count), 0);
        rst = 1'b0;
        exp_pix = 0;
        exp_oob = 0;
    endtask

    task automatic test_write_read;
        write_px(10, 20, 3'b101);
        read_px(10, 20);
        chk("wr_rd_color", int'(fb.rd_color), 3'b101);
        chk("wr_pix_count", int'(fb.pix_count), exp_pix);
    endtask

    task automatic test_clear;
        int n;
        fb.clear = 1'b1;
        tick();
        fb.clear = 1'b0;
        n = 0;
        while (fb.busy && n < 25000) begin
            // Drawer write attempted mid-clear must be dropped.
            if (n == 100) begin
                fb.VGA_x = 8'd5; fb.VGA_y = 7'd5; fb.VGA_color = 3'b111; fb.VGA_write = 1'b1;
            end else begin
                fb.VGA_write = 1'b0;
            end
            n++;
            tick();
        end
        fb.VGA_write = 1'b0;
        chk("clear_busy_cycles", n, W * H);
        chk("clear_done_pulse", int'(fb.clear_done), 1);
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                ref_mem[x][y] = 3'b000;
        exp_pix = 0;
        tick();
        chk("clear_done_single", int'(fb.clear_done), 0);
        read_px(159, 119);
        chk("clear_rd_159_119", int'(fb.rd_color), 0);
        read_px(0, 0);
        chk("clear_rd_0_0", int'(fb.rd_color), 0);
        read_px(5, 5);
        chk("clear_dropped_5_5", int'(fb.rd_color), int'(ref_mem[5][5]));
        chk("clear_pix_count", int'(fb.pix_count), exp_pix);
    endtask

    task automatic test_same_cycle;
        write_px(7, 3, 3'b001);
        fb.VGA_x = 8'd7; fb.VGA_y = 7'd3; fb.VGA_color = 3'b010; fb.VGA_write = 1'b1;
        fb.rd_x = 8'd7; fb.rd_y = 7'd3;
        tick();
        fb.VGA_write = 1'b0;
        chk("same_cycle_old", int'(fb.rd_color), 3'b001);
        ref_mem[7][3] = 3'b010;
        exp_pix++;
        tick();
        chk("same_cycle_new", int'(fb.rd_color), 3'b010);
    endtask

    task automatic test_random;
        int wx, wy, wc, rx, ry;
        logic [2:0] exp;
        for (int i = 0; i < 300; i++) begin
            wx = $urandom_range(0, W - 1);
            wy = $urandom_range(0, H - 1);
            wc = $urandom_range(0, 7);
            rx = $urandom_range(0, W - 1);
            ry = $urandom_range(0, H - 1);
            // Bias reads toward recently written locations half the time.
            if ($urandom_range(0, 1) == 1) begin rx = wx; ry = wy; end
            fb.VGA_x = 8'(wx); fb.VGA_y = 7'(wy); fb.VGA_color = 3'(wc);
            fb.VGA_write = 1'($urandom_range(0, 1));
            fb.rd_x = 8'(rx); fb.rd_y = 7'(ry);
            exp = ref_mem[rx][ry];
            if (fb.VGA_write) begin
                ref_mem[wx][wy] = 3'(wc);
                exp_pix++;
            end
            tick();
            chk("random_rd_color", int'(fb.rd_color), int'(exp));
        end
        fb.VGA_write = 1'b0;
        chk("random_pix_count", int'(fb.pix_count), exp_pix);
    endtask

    task automatic test_oob;
        fb.VGA_x = 8'd160; fb.VGA_y = 7'd0; fb.VGA_color = 3'b110; fb.VGA_write = 1'b1;
        tick();
        fb.VGA_write = 1'b0;
`ifdef PIXEL_FB_BOUNDS_CHECK_EN
        exp_oob++;
`else
        exp_pix++;
        ref_mem[160][0] = 3'b110;
        read_px(160, 0);
        chk("oob_stored", int'(fb.rd_color), 3'b110);
`endif
        chk("oob_pix_count", int'(fb.pix_count), exp_pix);
        chk("oob_oob_count", int'(fb.oob_count), exp_oob);
    endtask

    task automatic test_reset_mid_clear;
        write_px(0, 119, 3'b101);
        write_px(0, 0, 3'b011);
        fb.clear = 1'b1;
        tick();
        fb.clear = 1'b0;
        repeat (4999) tick();
        chk("mid_busy_before", int'(fb.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", int'(fb.busy), 0);
        chk("mid_clear_done", int'(fb.clear_done), 0);
        chk("mid_pix_count", int'(fb.pix_count), 0);
        chk("mid_oob_count", int'(fb.oob_count), 0);
        tick();
        chk("mid_stays_idle", int'(fb.busy), 0);
        read_px(0, 0);
        chk("mid_rd_0_0", int'(fb.rd_color), 0);
        read_px(0, 119);
        chk("mid_rd_0_119", int'(fb.rd_color), 3'b101);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        fb.VGA_x = '0; fb.VGA_y = '0; fb.VGA_color = '0; fb.VGA_write = 1'b0;
        fb.clear = 1'b0; fb.rd_x = '0; fb.rd_y = '0;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                ref_mem[x][y] = 3'b000;
        test_reset();
        test_write_read();
        test_clear();
        test_same_cycle();
        test_random();
        test_oob();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
- Receiving end of the drawer pixel-write interface (VGA_x, VGA_y, VGA_color, VGA_write) produced by the card and object drawing blocks.
- Stores each written pixel in an on-chip framebuffer.
- Provides a hardware clear-to-background sequencer and a registered read port for the VGA scan-out side and for checkers.

Parameters:
- RESOLUTION, "160x120", display mode; also accepts "320x240" and "640x480".
- nX, 8 (10 for 640x480, 9 for 320x240), x coordinate width.
- nY, 7 (9 for 640x480, 8 for 320x240), y coordinate width.
- WIDTH, 160 (640/320 per RESOLUTION), visible columns.
- HEIGHT, 120 (480/240 per RESOLUTION), visible rows.
- COLOR_DEPTH, 3, bits per pixel.
- BG_COLOR, 3'b000, colour written by the clear sequence.

Ports:
- Clock  in  1  single system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- VGA_x  in  nX  pixel column from drawer.
- VGA_y  in  nY  pixel row from drawer.
- VGA_color  in  COLOR_DEPTH  pixel colour from drawer.
- VGA_write  in  1  pixel write strobe, one pixel per cycle.
- clear  in  1  start clear sequence (level sampled in IDLE/DONE).
- busy  out  1  high while clearing; drawer writes dropped.
- clear_done  out  1  one-cycle pulse at end of clear.
- rd_x  in  nX  read column.
- rd_y  in  nY  read row.
- rd_color  out  COLOR_DEPTH  pixel at {rd_y,rd_x}, one-cycle latency.
- pix_count  out  16  accepted drawer writes, saturating.
- oob_count  out  16  dropped out-of-range writes, saturating (see optional feature).

Behaviour:
- Memory: depth 2^(nX+nY), address {y,x} (row-major concatenation, no multiply).
- Contents are not affected by Reset.
- Reset: state=IDLE; busy=0, clear_done=0, rd_color=0, pix_count=0, oob_count=0. Reset mid-clear aborts immediately; partially cleared contents remain.
- Clear FSM states IDLE, CLEAR, DONE:
  - IDLE: clear=1 -> CLEAR; clear counters cx=0, cy=0; pix_count<=0.
  - CLEAR: busy=1; each cycle writes BG_COLOR at {cy,cx}. cx increments 0..WIDTH-1, then wraps to 0 with cy+1. Exits after writing (WIDTH-1, HEIGHT-1) -> DONE. clear input ignored while in CLEAR.
  - DONE: clear_done=1, busy=0, for exactly one cycle. clear=1 in DONE -> CLEAR (restart, counters zeroed), else IDLE.
  - Timing: clear sampled at edge 0; CLEAR occupies edges 1..WIDTH*HEIGHT; clear_done high during the cycle after the final write (19200 write cycles for 160x120).
- Only visible area (x<WIDTH, y<HEIGHT) is cleared.
- Drawer write port:
  - VGA_write=1 while busy=0: memory[{VGA_y,VGA_x}] <= VGA_color at that edge; pix_count increments (saturate at 16'hFFFF).
  - VGA_write=1 while busy=1: dropped, no count change.
  - A write in the DONE cycle is accepted.
- Read port: rd_color <= memory[{rd_y,rd_x}] every edge; valid the cycle after the address is presented.
- Read of an address being written in the same cycle returns old data; new data is visible on the next read.
- Single write port: clear writes and drawer writes never coincide, because busy gates the drawer.

Optional Feature:
- Macro: PIXEL_FB_BOUNDS_CHECK_EN.
- Defined: drawer writes with VGA_x>=WIDTH or VGA_y>=HEIGHT (and busy=0) are not stored. oob_count increments (saturating); pix_count unchanged.
- Undefined: such writes are stored at {VGA_y,VGA_x} (off-screen region) and counted in pix_count. oob_count is tied to 0.

Test Plan:
- Reset, then write (10,20)=3'b101 → read (10,20) next cycle gives rd_color=3'b101; pix_count=1.
- Pulse clear with BG_COLOR=3'b000 → busy=1 for exactly 19200 cycles, then a single clear_done pulse; read (159,119) and (0,0) give 3'b000; pix_count=0.
- Write (5,5)=3'b111 while busy=1 → after clear completes, (5,5) reads 3'b000; pix_count unchanged.
- Same-cycle write and read of (7,3): write 3'b010 over old 3'b001 → rd_color=3'b001 on that read, 3'b010 on the following read.
- Write (160,0)=3'b110: with PIXEL_FB_BOUNDS_CHECK_EN → oob_count=1, pix_count=0; without → pix_count=1, read (160,0) gives 3'b110.
- Assert Reset midway through a clear (cycle 5000) → busy=0 and clear_done=0 next cycle, counters 0; pixel (0,0) already cleared reads BG_COLOR, pixel (0,119) retains its old value.
